// File: rtl/io_pkg.sv
// Shared types and defaults for the IO input FIFO.
// Holds the handshake FSM state encoding and the default width and depth.
package io_pkg;

   localparam int DefDataWidth = 8;
   localparam int DefDepth     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      HOLD  = 2'd2
   } fsmState_t;

endpackage

// File: rtl/io_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write, one async read.
// Ports: clk, wrEn/wrAddr/wrData (write), rdAddr/rdData (read). No reset.
module io_fifo_mem
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = DefDataWidth,
   parameter int DEPTH      = DefDepth
) (
   input  logic                       clk,
   input  logic                       wrEn,
   input  logic [$clog2(DEPTH)-1:0]   wrAddr,
   input  logic [DATA_WIDTH-1:0]      wrData,
   input  logic [$clog2(DEPTH)-1:0]   rdAddr,
   output logic [DATA_WIDTH-1:0]      rdData
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/io_in_fifo.sv
// Input FIFO with a four-phase (dataReady/ack) consumer handshake.
// Ports: clk, reset (async low), wrData/wrValid push side, full/empty/count
// status, sticky overflow + clrOverflow, dataOut/dataReady/ack consumer side.
// Optional macro IO_IN_FIFO_IRQ_EN adds irqEn input and registered irq output.
module io_in_fifo
   import io_pkg::*;
#(
   parameter int DATA_WIDTH = DefDataWidth,
   parameter int DEPTH      = DefDepth
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_WIDTH-1:0]      wrData,
   input  logic                       wrValid,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       clrOverflow,
   output logic [DATA_WIDTH-1:0]      dataOut,
   output logic                       dataReady,
   input  logic                       ack
`ifdef IO_IN_FIFO_IRQ_EN
   ,
   input  logic                       irqEn,
   output logic                       irq
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   fsmState_t state;
   fsmState_t nextState;

   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          push;
   logic          pop;
   logic          hasData;

   assign full    = (count == FullCnt);
   assign empty   = (count == '0);
   assign hasData = !empty;

   // full is the pre-edge value, so pop-from-full never frees room this edge
   assign push = wrValid && !full;
   assign pop  = (state == OFFER) && ack;

   io_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) uMem (
      .clk    (clk),
      .wrEn   (push),
      .wrAddr (wrPtr),
      .wrData (wrData),
      .rdAddr (rdPtr),
      .rdData (dataOut)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (hasData) begin
               nextState = OFFER;
            end
         end
         OFFER: begin
            if (ack) begin
               nextState = HOLD;
            end
         end
         HOLD: begin
            if (!ack) begin
               nextState = hasData ? OFFER : IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         dataReady <= 1'b0;
      end else begin
         state     <= nextState;
         dataReady <= (nextState == OFFER);
      end
   end

   // Set has priority over clear when both land on one edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (wrValid && full) begin
         overflow <= 1'b1;
      end else if (clrOverflow) begin
         overflow <= 1'b0;
      end
   end

`ifdef IO_IN_FIFO_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= irqEn && hasData;
      end
   end
`endif

endmodule

// File: tb/tb_io_in_fifo.sv
// Self-checking bench for io_in_fifo: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_io_in_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] wrData = '0;
   logic          wrValid = 1'b0;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          clrOverflow = 1'b0;
   logic [DW-1:0] dataOut;
   logic          dataReady;
   logic          ack = 1'b0;
`ifdef IO_IN_FIFO_IRQ_EN
   logic          irqEn = 1'b0;
   logic          irq;
`endif

   int total = 0;
   int bad = 0;

   // Reference model: stored bytes, consumer phase, sticky flags
   logic [DW-1:0] q[$];
   int  phase;   // 0 waiting for data, 1 byte offered, 2 ack still high
   bit  ovfM;
   bit  irqM;

   io_in_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .wrData      (wrData),
      .wrValid     (wrValid),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .clrOverflow (clrOverflow),
      .dataOut     (dataOut),
      .dataReady   (dataReady),
      .ack         (ack)
`ifdef IO_IN_FIFO_IRQ_EN
      ,
      .irqEn       (irqEn),
      .irq         (irq)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      q.delete();
      phase = 0;
      ovfM = 0;
      irqM = 0;
   endtask

   task automatic chkAll(input string tag);
      chk({tag, ":count"}, 32'(count), 32'(q.size()));
      chk({tag, ":full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ":empty"}, 32'(empty), 32'(q.size() == 0));
      chk({tag, ":rdy"}, 32'(dataReady), 32'(phase == 1));
      chk({tag, ":ovf"}, 32'(overflow), 32'(ovfM));
      if (phase == 1 && q.size() > 0) begin
         chk({tag, ":data"}, 32'(dataOut), 32'(q[0]));
      end
`ifdef IO_IN_FIFO_IRQ_EN
      chk({tag, ":irq"}, 32'(irq), 32'(irqM));
`endif
   endtask

   task automatic step(input string tag, input bit wv, input logic [DW-1:0] d,
                       input bit a, input bit clr, input bit ie);
      int  pre;
      bit  popNow;
      wrValid = wv;
      wrData = d;
      ack = a;
      clrOverflow = clr;
`ifdef IO_IN_FIFO_IRQ_EN
      irqEn = ie;
`endif
      @(posedge clk);
      pre = q.size();
      popNow = (phase == 1) && a;
      if (wv && pre == DEPTH) ovfM = 1;
      else if (clr) ovfM = 0;
      if (popNow) void'(q.pop_front());
      if (wv && pre < DEPTH) q.push_back(d);
      case (phase)
         0: phase = (pre > 0) ? 1 : 0;
         1: phase = a ? 2 : 1;
         default: phase = a ? 2 : ((pre > 0) ? 1 : 0);
      endcase
      irqM = ie && (pre > 0);
      #1;
      chkAll(tag);
   endtask

   initial begin
      modelReset();
      #2;
      chk("rst:count", 32'(count), 0);
      chk("rst:empty", 32'(empty), 1);
      chk("rst:full", 32'(full), 0);
      chk("rst:rdy", 32'(dataReady), 0);
      chk("rst:ovf", 32'(overflow), 0);
      #10 reset = 1'b1;

      // single byte, two-edge latency, four-phase handshake
      step("s1push", 1, 8'h5A, 0, 0, 1);
      chk("s1:notyet", 32'(dataReady), 0);
      step("s1wait", 0, 8'h00, 0, 0, 1);
      chk("s1:lat", 32'(dataReady), 1);
      chk("s1:byte", 32'(dataOut), 32'h5A);
      step("s1ack", 0, 8'h00, 1, 0, 1);
      chk("s1:cnt0", 32'(count), 0);
      step("s1rel", 0, 8'h00, 0, 0, 1);
      step("s1idle", 0, 8'h00, 1, 0, 1);
      chk("s1:idleack", 32'(dataReady), 0);

      // fill, overflow, drain in order
      for (int i = 1; i <= 8; i++) step("fill", 1, 8'(i), 0, 0, 0);
      chk("fill:full", 32'(full), 1);
      chk("fill:cnt8", 32'(count), 8);
      step("ovf", 1, 8'hFF, 0, 1, 0);
      chk("ovf:set", 32'(overflow), 1);
      for (int i = 0; i < 8; i++) begin
         step("drA", 0, 8'h00, 1, 0, 0);
         step("drR", 0, 8'h00, 0, 0, 0);
      end
      chk("drain:empty", 32'(empty), 1);
      step("clr", 0, 8'h00, 0, 1, 0);
      chk("clr:ovf", 32'(overflow), 0);

      // ack held high in HOLD pops only once
      for (int i = 0; i < 3; i++) step("h3", 1, 8'h20 + 8'(i), 0, 0, 0);
      step("h3w", 0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("hold", 0, 8'h00, 1, 0, 0);
      chk("hold:cnt", 32'(count), 2);
      step("holdRel", 0, 8'h00, 0, 0, 0);
      step("holdRel2", 0, 8'h00, 0, 0, 0);
      chk("hold:next", 32'(dataOut), 32'h21);

      // simultaneous push and pop with 4 stored
      step("p4a", 1, 8'h30, 0, 0, 0);
      step("p4b", 1, 8'h31, 0, 0, 0);
      chk("p4:cnt", 32'(count), 4);
      step("pushPop", 1, 8'h33, 1, 0, 0);
      chk("pp:cnt", 32'(count), 4);

      // reset in the middle of an offer
      step("rr", 0, 8'h00, 0, 0, 0);
      step("rr2", 0, 8'h00, 0, 0, 0);
      step("rr3", 0, 8'h00, 0, 0, 0);
      reset = 1'b0;
      #1;
      modelReset();
      chk("midrst:rdy", 32'(dataReady), 0);
      chk("midrst:cnt", 32'(count), 0);
      reset = 1'b1;
      step("afterRst", 0, 8'h00, 0, 0, 0);
      chk("afterRst:empty", 32'(empty), 1);

      // randomized traffic including pops from full with push
      for (int i = 0; i < 600; i++) begin
         step("rand", $urandom_range(0, 99) < 55, 8'($urandom),
              $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 6,
              $urandom_range(0, 99) < 70);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
